instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning instruction/PC word width (fixed field slicing assumes 32).
REQ-002 SHALL have parameter DEPTH, default 8, meaning queue entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the one clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous queue clear.
REQ-006 SHALL have port in_valid  input  1  upstream word present.
REQ-007 SHALL have port in_data  input  WIDTH  raw instruction word.
REQ-008 SHALL have port in_ready  output  1  queue can accept.
REQ-009 SHALL have port out_valid  output  1  head entry present.
REQ-010 SHALL have port out_ready  input  1  decode/ALU stage consumes head.
REQ-011 SHALL have ports out_opcode[6:0], out_rd[4:0], out_funct3[2:0], out_rs1[4:0], out_rs2[4:0], out_funct7[6:0]  output, meaning head fields from bits [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].
REQ-012 SHALL have port out_pc  output  WIDTH  byte address of head instruction.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-014 SHALL push in_data when in_valid && in_ready at a rising clk edge.
REQ-015 SHALL pop the head when out_valid && out_ready at a rising clk edge.
REQ-016 SHALL drive in_ready = (count < DEPTH) && !flush, from registered state only, independent of out_ready.
REQ-017 SHALL drive out_valid = (count != 0); fields and out_pc decoded combinationally from the head entry.
REQ-018 SHALL exhibit one-cycle latency: word pushed at edge N appears at the output after edge N if the queue was empty.
REQ-019 SHALL keep count unchanged on simultaneous push and pop; +1 push only; -1 pop only.
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL tag each pushed word with a fetch PC starting at 0, incremented by 4 per push, wrapping modulo 2^WIDTH.
REQ-022 SHALL hold output fields stable while out_valid && !out_ready.
REQ-023 SHALL on flush clear count and pointers and reset the fetch PC to 0; flush overrides push and pop in the same cycle; the word offered then is not accepted.
REQ-024 SHALL not push when full or pop when empty, regardless of in_valid/out_ready.

Reset
REQ-025 SHALL on rst asynchronously clear pointers, count, and fetch PC to 0; in_ready=1, out_valid=0, all field outputs and out_pc read 0.
REQ-026 SHALL drop all queued entries when rst asserts mid-operation; storage contents need not be cleared.
REQ-027 SHALL release from reset synchronously to clk, first push possible at the first edge with rst low.

Configuration
REQ-028 SHALL, with macro FETCHQ_RTYPE_CHECK_EN defined, add output out_illegal (1 bit) = out_valid && (out_opcode != 7'b0110011); illegal entries are still delivered and popped normally; out_illegal reset value 0.
REQ-029 SHALL, without FETCHQ_RTYPE_CHECK_EN, omit out_illegal and contain no opcode comparison logic.

Structure
REQ-030 SHALL place in shared package riscv_pkg: OPC_RTYPE (7'b0110011), field bit-position constants, PC increment constant (4).
REQ-031 SHALL implement storage as sub-module fetchq_mem (DEPTH x (2*WIDTH) register array, one write port, one async read port, no reset).
REQ-032 SHALL keep pointer/count/PC control in instr_fetch_queue itself.

Verification
REQ-033 SHALL cover: reset, push 0x002081B3 -> next cycle out_valid=1, opcode=0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, out_pc=0.
REQ-034 SHALL cover: push 8 words with out_ready=0 -> count=8, in_ready=0; 9th in_valid not accepted; drain yields out_pc 0,4,...,28 in order.
REQ-035 SHALL cover: continuous push and pop with count=3 for 20 cycles -> count stays 3, pointers wrap, order preserved.
REQ-036 SHALL cover: flush with count=5 and in_valid=1 -> next cycle count=0, out_valid=0; next push gets out_pc=0.
REQ-037 SHALL cover: rst asserted asynchronously mid-stream -> out_valid=0, count=0 immediately, before next clk edge.
REQ-038 SHALL cover, with FETCHQ_RTYPE_CHECK_EN: push 0x00000013 -> out_illegal=1; push 0x40208233 -> out_illegal=0, funct7=0x20.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V constants: R-type opcode, instruction field
//               bit positions and the sequential fetch PC step.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Opcode of register-register ALU instructions
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    // Instruction field bit positions (32-bit encoding)
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    // Byte distance between consecutive fetched instructions
    localparam int PC_INCR = 4;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetchq_mem.sv
`default_nettype none
// ============================================================================
// Module      : fetchq_mem
// Description : Fetch-queue storage: DEPTH entries, one synchronous write
//               port, one asynchronous read port, contents not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fetchq_mem #(
    parameter int ENTRY_W = 64,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRY_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    // Write one entry per accepted push; no reset, stale data is masked by count
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : fetchq_mem
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Instruction fetch FIFO. Tags each accepted word with a
//               sequential fetch PC and presents the head entry pre-split
//               into RISC-V fields. Optional macro FETCHQ_RTYPE_CHECK_EN adds
//               out_illegal, flagging heads whose opcode is not R-type.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               out_opcode,
    output logic [4:0]               out_rd,
    output logic [2:0]               out_funct3,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [6:0]               out_funct7,
    output logic [WIDTH-1:0]         out_pc,
`ifdef FETCHQ_RTYPE_CHECK_EN
    output logic                     out_illegal,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_pc;

    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_rd_entry;
    logic [WIDTH-1:0]   w_head_data;

    // Handshakes; flush blocks both directions for the cycle it is asserted
    assign in_ready  = (r_count < CNT_FULL) && !flush;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;
    assign count     = r_count;

    // Pointer, occupancy and fetch-PC bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pc     <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pc     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_pc     <= r_pc + WIDTH'(PC_INCR);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Each entry carries {fetch PC, raw instruction word}
    fetchq_mem #(
        .ENTRY_W (2 * WIDTH),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata ({r_pc, in_data}),
        .raddr (r_rd_ptr),
        .rdata (w_rd_entry)
    );

    // Empty queue presents all-zero fields so uninitialised storage never leaks
    assign w_head_data = out_valid ? w_rd_entry[WIDTH-1:0]       : '0;
    assign out_pc      = out_valid ? w_rd_entry[2*WIDTH-1:WIDTH] : '0;

    assign out_opcode = w_head_data[OPCODE_MSB:OPCODE_LSB];
    assign out_rd     = w_head_data[RD_MSB:RD_LSB];
    assign out_funct3 = w_head_data[FUNCT3_MSB:FUNCT3_LSB];
    assign out_rs1    = w_head_data[RS1_MSB:RS1_LSB];
    assign out_rs2    = w_head_data[RS2_MSB:RS2_LSB];
    assign out_funct7 = w_head_data[FUNCT7_MSB:FUNCT7_LSB];

`ifdef FETCHQ_RTYPE_CHECK_EN
    assign out_illegal = out_valid && (out_opcode != OPC_RTYPE);
`endif

endmodule : instr_fetch_queue
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue: a table of
//               single-cycle vectors plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [31:0] out_pc;
    logic [3:0]  count;
`ifdef FETCHQ_RTYPE_CHECK_EN
    logic        out_illegal;
`endif

    int n_pass  = 0;
    int n_total = 0;

    wire [31:0] head_word = {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode};

    always #5 clk = ~clk;

    instr_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_funct3 (out_funct3),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_funct7 (out_funct7),
        .out_pc     (out_pc),
`ifdef FETCHQ_RTYPE_CHECK_EN
        .out_illegal(out_illegal),
`endif
        .count      (count)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_valid;
        logic [3:0]  e_count;
        logic        e_in_ready;
        logic [31:0] e_pc;
        logic [31:0] e_word;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drive one cycle, go idle after the edge, then let outputs settle
    task automatic apply(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
        flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk); #1;
        idle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #12;
        // ---------------- reset state ----------------
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_pc",    out_pc,         32'd0);
        chk("rst_head_word", head_word,      32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- basic push + field decode ----------------
        in_valid = 1'b1; in_data = 32'h002081B3;
        #1 chk("lat_pre_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        idle(); #1;
        chk("add_valid",  32'(out_valid),  32'd1);
        chk("add_opcode", 32'(out_opcode), 32'h33);
        chk("add_rd",     32'(out_rd),     32'd3);
        chk("add_rs1",    32'(out_rs1),    32'd1);
        chk("add_rs2",    32'(out_rs2),    32'd2);
        chk("add_funct3", 32'(out_funct3), 32'd0);
        chk("add_funct7", 32'(out_funct7), 32'd0);
        chk("add_pc",     out_pc,          32'd0);

        // ---------------- table-driven vectors ----------------
        do_reset();
        //              fl    iv    data          ordy  valid cnt  inrdy pc      word
        vecs[0] = '{1'b0, 1'b1, 32'h002081B3, 1'b0, 1'b1, 4'd1, 1'b1, 32'd0,  32'h002081B3};
        vecs[1] = '{1'b0, 1'b1, 32'h40208233, 1'b0, 1'b1, 4'd2, 1'b1, 32'd0,  32'h002081B3};
        vecs[2] = '{1'b0, 1'b1, 32'h00000013, 1'b1, 1'b1, 4'd2, 1'b1, 32'd4,  32'h40208233};
        vecs[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 4'd1, 1'b1, 32'd8,  32'h00000013};
        vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 1'b1, 32'd0,  32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 1'b1, 32'd0,  32'h0};
        vecs[6] = '{1'b1, 1'b1, 32'h00A00093, 1'b0, 1'b0, 4'd0, 1'b1, 32'd0,  32'h0};
        vecs[7] = '{1'b0, 1'b1, 32'h00A00093, 1'b0, 1'b1, 4'd1, 1'b1, 32'd0,  32'h00A00093};
        vecs[8] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 1'b1, 32'd0,  32'h0};
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk($sformatf("vec%0d_valid", i),    32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_count", i),    32'(count),     32'(vecs[i].e_count));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready),  32'(vecs[i].e_in_ready));
            chk($sformatf("vec%0d_pc", i),       out_pc,         vecs[i].e_pc);
            chk($sformatf("vec%0d_word", i),     head_word,      vecs[i].e_word);
        end

        // ---------------- fill to full, reject 9th, drain in order ----------------
        do_reset();
        for (int i = 0; i < DEPTH; i++) apply(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
        chk("full_count",    32'(count),    32'd8);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        apply(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("ninth_count",   32'(count),    32'd8);
        chk("ninth_head",    head_word,     32'h100);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d_pc", i),   out_pc,    32'(4 * i));
            chk($sformatf("drain%0d_word", i), head_word, 32'h100 + 32'(i));
            apply(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        // ---------------- steady push+pop at count 3 ----------------
        do_reset();
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 32'h1000 + 32'(i), 1'b0);
        for (int k = 0; k < 20; k++) begin
            apply(1'b0, 1'b1, 32'h1000 + 32'(k + 3), 1'b1);
            chk($sformatf("stream%0d_count", k), 32'(count), 32'd3);
            chk($sformatf("stream%0d_word", k),  head_word,  32'h1000 + 32'(k + 1));
            chk($sformatf("stream%0d_pc", k),    out_pc,     32'(4 * (k + 1)));
        end

        // ---------------- flush with count 5 and a word offered ----------------
        do_reset();
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 32'h2000 + 32'(i), 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h0BADF00D; out_ready = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        idle(); #1;
        chk("flush_count", 32'(count),     32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        apply(1'b0, 1'b1, 32'h002081B3, 1'b0);
        chk("post_flush_pc",   out_pc,    32'd0);
        chk("post_flush_word", head_word, 32'h002081B3);

        // ---------------- asynchronous reset mid-stream ----------------
        do_reset();
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 32'h3000 + 32'(i), 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count),     32'd0);
        chk("arst_pc",    out_pc,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 1'b1, 32'h00C00113, 1'b0);
        chk("arst_first_push_count", 32'(count), 32'd1);
        chk("arst_first_push_pc",    out_pc,     32'd0);

`ifdef FETCHQ_RTYPE_CHECK_EN
        // ---------------- R-type legality flag ----------------
        do_reset();
        chk("ill_reset", 32'(out_illegal), 32'd0);
        apply(1'b0, 1'b1, 32'h00000013, 1'b0);
        chk("ill_addi", 32'(out_illegal), 32'd1);
        apply(1'b0, 1'b1, 32'h40208233, 1'b1);
        chk("ill_sub",        32'(out_illegal), 32'd0);
        chk("ill_sub_funct7", 32'(out_funct7),  32'h20);
        chk("ill_sub_pc",     out_pc,           32'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run cannot hang
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_instr_fetch_queue
`default_nettype wire
